// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, 11-bit frame capture,
// and a scan-code-set-2 prefix decoder producing single make/break key events.
module ps2_key_decoder #(
  parameter int FILTER_LEN      = 4,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter bit PASS_EXT        = 1'b0,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_is_press,
  output logic       key_en,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_flt;
  logic [FW-1:0] r_flt_cnt;
  logic          r_strobe;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  state_t        r_state;
  logic [2:0]    r_skip;
  logic [7:0]    r_last_press;

  logic [7:0]    w_byte;
  logic          w_stop_strobe;
  logic          w_frame_ok;
  logic          w_emit;
  logic          w_press;
  state_t        w_next_state;
  logic [2:0]    w_next_skip;

  // Shift register fills MSB-first, so after 10 bits: [0]=start, [8:1]=data, [9]=parity.
  assign w_byte        = r_shift[8:1];
  assign w_stop_strobe = r_strobe && (r_bit_cnt == 4'd10);
  assign w_frame_ok    = w_stop_strobe && !r_shift[0] && (^r_shift[9:1]) && r_dat_s2;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_emit       = 1'b0;
    w_press      = 1'b0;
    w_next_state = r_state;
    w_next_skip  = r_skip;
    unique case (r_state)
      S_IDLE: begin
        if (w_byte == 8'hF0)      w_next_state = S_BRK;
        else if (w_byte == 8'hE0) w_next_state = S_EXT;
        else if (w_byte == 8'hE1) begin
          w_next_state = S_PAUSE;
          w_next_skip  = 3'd7;
        end else if (!(w_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
          w_emit  = 1'b1;
          w_press = 1'b1;
        end
      end
      S_BRK: begin
        w_emit       = 1'b1;
        w_next_state = S_IDLE;
      end
      S_EXT: begin
        if (w_byte == 8'hF0) w_next_state = S_EXT_BRK;
        else begin
          w_emit       = PASS_EXT;
          w_press      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_EXT_BRK: begin
        w_emit       = PASS_EXT;
        w_next_state = S_IDLE;
      end
      S_PAUSE: begin
        w_next_skip = r_skip - 3'd1;
        if (r_skip == 3'd1) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // Typematic repeat of the key already held down is swallowed.
    if (SUPPRESS_REPEAT && w_press && (w_byte == r_last_press)) w_emit = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_flt    <= 1'b1;
      r_flt_cnt    <= '0;
      r_strobe     <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_to_cnt     <= '0;
      r_state      <= S_IDLE;
      r_skip       <= '0;
      r_last_press <= '0;
      keycode      <= '0;
      key_is_press <= 1'b0;
      key_en       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_dat_s1  <= ps2_data;
      r_dat_s2  <= r_dat_s1;
      r_strobe  <= 1'b0;
      key_en    <= 1'b0;
      frame_err <= 1'b0;

      // Filtered clock flips after FILTER_LEN consecutive samples disagree with it.
      if (r_clk_s2 != r_clk_flt) begin
        if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
          r_clk_flt <= r_clk_s2;
          r_flt_cnt <= '0;
          r_strobe  <= ~r_clk_s2;
        end else begin
          r_flt_cnt <= r_flt_cnt + 1'b1;
        end
      end else begin
        r_flt_cnt <= '0;
      end

      if (r_strobe) begin
        r_to_cnt <= '0;
        if (w_stop_strobe) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            r_state <= w_next_state;
            r_skip  <= w_next_skip;
            key_en  <= w_emit;
            if (w_emit) begin
              keycode      <= w_byte;
              key_is_press <= w_press;
              if (w_press)                        r_last_press <= w_byte;
              else if (w_byte == r_last_press)    r_last_press <= '0;
            end
          end else begin
            frame_err <= 1'b1;
            r_state   <= S_IDLE;
          end
        end else begin
          r_shift   <= {r_dat_s2, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= '0;
          r_to_cnt  <= '0;
          frame_err <= 1'b1;
          r_state   <= S_IDLE;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: two instances (extended keys dropped / passed)
// share the PS/2 pins; a negedge monitor tallies key events and frame errors.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 3000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode0, keycode1;
  logic       press0, press1, en0, en1, err0, err1;

  int total = 0;
  int bad   = 0;

  int         n_ev0 = 0, n_ev1 = 0, n_err0 = 0, n_err1 = 0;
  logic [7:0] last_code0 = '0, last_code1 = '0;
  logic       last_press0 = 1'b0, last_press1 = 1'b0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT), .PASS_EXT(1'b0), .SUPPRESS_REPEAT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode0), .key_is_press(press0), .key_en(en0), .frame_err(err0));

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT), .PASS_EXT(1'b1), .SUPPRESS_REPEAT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode1), .key_is_press(press1), .key_en(en1), .frame_err(err1));

  always @(negedge clk) begin
    if (!reset) begin
      if (en0) begin n_ev0++; last_code0 = keycode0; last_press0 = press0; end
      if (en1) begin n_ev1++; last_code1 = keycode1; last_press1 = press1; end
      if (err0) n_err0++;
      if (err1) n_err1++;
    end
  end

  task automatic drive_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((~^d) ^ flip_par);
    drive_bit(1'b1);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_partial();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (keycode0 !== 8'h00) begin bad++; $display("FAIL reset_keycode got=%h want=00", keycode0); end
    total++; if (press0 !== 1'b0) begin bad++; $display("FAIL reset_press got=%b want=0", press0); end
    total++; if (en0 !== 1'b0 || en1 !== 1'b0) begin bad++; $display("FAIL reset_en got=%b%b want=00", en0, en1); end
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err0); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make();
    int b0 = n_ev0, b1 = n_ev1, e0 = n_err0;
    send_frame(8'h15, 1'b0);
    total++; if (n_ev0 !== b0 + 1) begin bad++; $display("FAIL make_count got=%0d want=%0d", n_ev0, b0 + 1); end
    total++; if (last_code0 !== 8'h15 || last_press0 !== 1'b1) begin bad++; $display("FAIL make_event got=%h/%b want=15/1", last_code0, last_press0); end
    total++; if (n_ev1 !== b1 + 1 || last_code1 !== 8'h15) begin bad++; $display("FAIL make_dut1 got=%0d/%h want=%0d/15", n_ev1, last_code1, b1 + 1); end
    total++; if (keycode0 !== 8'h15 || press0 !== 1'b1 || en0 !== 1'b0) begin bad++; $display("FAIL make_hold got=%h/%b/%b want=15/1/0", keycode0, press0, en0); end
    total++; if (n_err0 !== e0) begin bad++; $display("FAIL make_noerr got=%0d want=%0d", n_err0, e0); end
  endtask

  task automatic test_break();
    int b0 = n_ev0;
    send_frame(8'hF0, 1'b0);
    total++; if (n_ev0 !== b0) begin bad++; $display("FAIL break_prefix got=%0d want=%0d", n_ev0, b0); end
    send_frame(8'h15, 1'b0);
    total++; if (n_ev0 !== b0 + 1) begin bad++; $display("FAIL break_count got=%0d want=%0d", n_ev0, b0 + 1); end
    total++; if (last_code0 !== 8'h15 || last_press0 !== 1'b0) begin bad++; $display("FAIL break_event got=%h/%b want=15/0", last_code0, last_press0); end
  endtask

  task automatic test_repeat();
    int b0 = n_ev0;
    for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0);
    total++; if (n_ev0 !== b0 + 1) begin bad++; $display("FAIL repeat_press_count got=%0d want=%0d", n_ev0, b0 + 1); end
    total++; if (last_code0 !== 8'h1C || last_press0 !== 1'b1) begin bad++; $display("FAIL repeat_press got=%h/%b want=1c/1", last_code0, last_press0); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    total++; if (n_ev0 !== b0 + 2) begin bad++; $display("FAIL repeat_total got=%0d want=%0d", n_ev0, b0 + 2); end
    total++; if (last_code0 !== 8'h1C || last_press0 !== 1'b0) begin bad++; $display("FAIL repeat_release got=%h/%b want=1c/0", last_code0, last_press0); end
  endtask

  task automatic test_parity();
    int b0 = n_ev0, e0 = n_err0;
    send_frame(8'h15, 1'b1);
    total++; if (n_err0 !== e0 + 1) begin bad++; $display("FAIL parity_err got=%0d want=%0d", n_err0, e0 + 1); end
    total++; if (n_ev0 !== b0) begin bad++; $display("FAIL parity_noevent got=%0d want=%0d", n_ev0, b0); end
    send_frame(8'h1C, 1'b0);
    total++; if (n_ev0 !== b0 + 1 || last_code0 !== 8'h1C || last_press0 !== 1'b1) begin bad++; $display("FAIL parity_recover got=%0d/%h/%b want=%0d/1c/1", n_ev0, last_code0, last_press0, b0 + 1); end
    total++; if (n_err0 !== e0 + 1) begin bad++; $display("FAIL parity_single got=%0d want=%0d", n_err0, e0 + 1); end
  endtask

  task automatic test_timeout();
    int b0 = n_ev0, e0 = n_err0;
    send_partial();
    repeat (TIMEOUT + 100) @(negedge clk);
    total++; if (n_err0 !== e0 + 1) begin bad++; $display("FAIL timeout_err got=%0d want=%0d", n_err0, e0 + 1); end
    total++; if (n_ev0 !== b0) begin bad++; $display("FAIL timeout_noevent got=%0d want=%0d", n_ev0, b0); end
    send_frame(8'h15, 1'b0);
    total++; if (n_ev0 !== b0 + 1 || last_code0 !== 8'h15 || last_press0 !== 1'b1) begin bad++; $display("FAIL timeout_recover got=%0d/%h/%b want=%0d/15/1", n_ev0, last_code0, last_press0, b0 + 1); end
    total++; if (n_err0 !== e0 + 1) begin bad++; $display("FAIL timeout_single got=%0d want=%0d", n_err0, e0 + 1); end
  endtask

  task automatic test_reset_mid();
    int b0 = n_ev0, e0 = n_err0;
    send_partial();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h1C, 1'b0);
    total++; if (n_err0 !== e0) begin bad++; $display("FAIL rstmid_noerr got=%0d want=%0d", n_err0, e0); end
    total++; if (n_ev0 !== b0 + 1 || last_code0 !== 8'h1C || last_press0 !== 1'b1) begin bad++; $display("FAIL rstmid_event got=%0d/%h/%b want=%0d/1c/1", n_ev0, last_code0, last_press0, b0 + 1); end
  endtask

  task automatic test_ext_pause();
    logic [7:0] seq [10];
    int b0 = n_ev0, b1 = n_ev1;
    seq = '{8'hE0, 8'h74, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 10; i++) send_frame(seq[i], 1'b0);
    total++; if (n_ev0 !== b0) begin bad++; $display("FAIL ext_drop got=%0d want=%0d", n_ev0, b0); end
    total++; if (n_ev1 !== b1 + 1 || last_code1 !== 8'h74 || last_press1 !== 1'b1) begin bad++; $display("FAIL ext_pass got=%0d/%h/%b want=%0d/74/1", n_ev1, last_code1, last_press1, b1 + 1); end
    send_frame(8'h15, 1'b0);
    total++; if (n_ev0 !== b0 + 1 || last_code0 !== 8'h15 || last_press0 !== 1'b1) begin bad++; $display("FAIL ext_after0 got=%0d/%h/%b want=%0d/15/1", n_ev0, last_code0, last_press0, b0 + 1); end
    total++; if (n_ev1 !== b1 + 2 || last_code1 !== 8'h15) begin bad++; $display("FAIL ext_after1 got=%0d/%h want=%0d/15", n_ev1, last_code1, b1 + 2); end
    total++; if (n_err0 !== n_err1) begin bad++; $display("FAIL err_agree got=%0d want=%0d", n_err1, n_err0); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_repeat();
    test_parity();
    test_timeout();
    test_reset_mid();
    test_ext_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
